// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared control constants for the multi-cycle CPU controller.
// CTRL_ILLEGAL_TRAP_EN adds the TRAP state for unknown opcodes.
package cpu_ctrl_fsm_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP   = 3'd6;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic lui;
    logic jal;
  } opclass_t;

endpackage

// File: rtl/cpu_opclass_dec.sv
// Combinational opcode classifier: 7-bit opcode in, one-hot class out.
// All-zero output marks an unclassified opcode.
module cpu_opclass_dec
  import cpu_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:      cls.r      = 1'b1;
      OP_I:      cls.i      = 1'b1;
      OP_LOAD:   cls.load   = 1'b1;
      OP_STORE:  cls.store  = 1'b1;
      OP_BRANCH: cls.branch = 1'b1;
      OP_LUI:    cls.lui    = 1'b1;
      OP_JAL:    cls.jal    = 1'b1;
      default:   cls        = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/exec/mem/wb controller with retire counter.
// Define CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes instead of NOPing.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter int IW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_i,
  input  logic [IW-1:0] instr_i,
  input  logic          mem_ready_i,
  input  logic          zero_i,
  output logic          ir_write_o,
  output logic          pc_inc_o,
  output logic          pc_branch_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          addr_sel_o,
  output logic          alu_src_b_o,
  output logic [1:0]    alu_op_o,
  output logic [1:0]    wb_sel_o,
  output logic          regwrite_o,
  output logic [2:0]    state_o,
  output logic          illegal_o,
  output logic [CW-1:0] retired_o
);

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [2:0]    done_st;
  logic [6:0]    opc_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] ret_q;
  logic          retire;
  opclass_t      cls;
  logic          unused_instr;

  assign unused_instr = ^instr_i[IW-1:12];

  cpu_opclass_dec u_dec (
    .opcode (opc_q),
    .cls    (cls)
  );

  // Retire point decides whether to keep fetching or park.
  assign done_st   = run_i ? S_FETCH : S_IDLE;
  assign state_o   = state_q;
  assign retired_o = ret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      rd_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ir_write_o) begin
        opc_q <= instr_i[6:0];
        rd_q  <= instr_i[11:7];
      end
      if (retire) ret_q <= ret_q + CW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    ir_write_o  = 1'b0;
    pc_inc_o    = 1'b0;
    pc_branch_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    addr_sel_o  = 1'b0;
    alu_src_b_o = 1'b0;
    alu_op_o    = ALU_ADD;
    wb_sel_o    = WB_ALU;
    regwrite_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_inc_o   = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls != '0) begin
          state_d = S_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          retire  = 1'b1;
          state_d = done_st;
`endif
        end
      end
      S_EXEC: begin
        if (cls.r || cls.i)  alu_op_o = ALU_FN;
        else if (cls.branch) alu_op_o = ALU_SUB;
        alu_src_b_o = cls.i | cls.load | cls.store | cls.lui;
        unique case (1'b1)
          cls.r, cls.i, cls.lui: state_d = S_WB;
          cls.load, cls.store:   state_d = S_MEM;
          cls.branch: begin
            pc_branch_o = zero_i;
            retire      = 1'b1;
            state_d     = done_st;
          end
          cls.jal: begin
            pc_branch_o = 1'b1;
            state_d     = S_WB;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_MEM: begin
        addr_sel_o  = 1'b1;
        mem_read_o  = cls.load;
        mem_write_o = cls.store & ~cls.load;
        if (mem_ready_i) begin
          if (cls.load) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = done_st;
          end
        end
      end
      S_WB: begin
        regwrite_o = (rd_q != 5'd0);
        if (cls.load)     wb_sel_o = WB_MEM;
        else if (cls.jal) wb_sel_o = WB_PC4;
        retire  = 1'b1;
        state_d = done_st;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_o = (state_q == S_TRAP);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: vector table plus reset and
// illegal-opcode sequences.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_i;
  logic [31:0] instr_i;
  logic        mem_ready_i;
  logic        zero_i;
  logic        ir_write_o;
  logic        pc_inc_o;
  logic        pc_branch_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        addr_sel_o;
  logic        alu_src_b_o;
  logic [1:0]  alu_op_o;
  logic [1:0]  wb_sel_o;
  logic        regwrite_o;
  logic [2:0]  state_o;
  logic        illegal_o;
  logic [31:0] retired_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_ctrl_fsm #(.IW(32), .CW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .run_i       (run_i),
    .instr_i     (instr_i),
    .mem_ready_i (mem_ready_i),
    .zero_i      (zero_i),
    .ir_write_o  (ir_write_o),
    .pc_inc_o    (pc_inc_o),
    .pc_branch_o (pc_branch_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .addr_sel_o  (addr_sel_o),
    .alu_src_b_o (alu_src_b_o),
    .alu_op_o    (alu_op_o),
    .wb_sel_o    (wb_sel_o),
    .regwrite_o  (regwrite_o),
    .state_o     (state_o),
    .illegal_o   (illegal_o),
    .retired_o   (retired_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          mem_cyc;
    int          n;
    logic [11:0] trace;
    int          rw;
    int          br;
    logic [1:0]  wb;
    logic [1:0]  alu;
    logic        srcb;
    int          macc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  initial begin
    int exp_ret;
    // instr, zero, mem_cyc, n, trace, rw, br, wb, alu, srcb, macc
    vecs[0] = '{32'h002081B3, 1'b0, 0, 4, 12'o1235, 1, 0,
                2'b00, 2'b10, 1'b0, 0};
    vecs[1] = '{32'h0000A103, 1'b0, 3, 7, 12'o4445, 1, 0,
                2'b01, 2'b00, 1'b1, 3};
    vecs[2] = '{32'h00208463, 1'b1, 0, 3, 12'o0123, 0, 1,
                2'b00, 2'b01, 1'b0, 0};
    vecs[3] = '{32'h00208463, 1'b0, 0, 3, 12'o0123, 0, 0,
                2'b00, 2'b01, 1'b0, 0};
    vecs[4] = '{32'h00000013, 1'b0, 0, 4, 12'o1235, 0, 0,
                2'b00, 2'b10, 1'b1, 0};
    vecs[5] = '{32'h00112023, 1'b0, 1, 4, 12'o1234, 0, 0,
                2'b00, 2'b00, 1'b1, 1};
    vecs[6] = '{32'h000012B7, 1'b0, 0, 4, 12'o1235, 1, 0,
                2'b00, 2'b00, 1'b1, 0};
    vecs[7] = '{32'h008000EF, 1'b0, 0, 4, 12'o1235, 1, 1,
                2'b10, 2'b00, 1'b0, 0};

    rst = 1'b1;
    run_i = 1'b1;
    instr_i = '0;
    mem_ready_i = 1'b1;
    zero_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_retired", retired_o, 32'd0);
    chk("rst_illegal", 32'(illegal_o), 32'd0);
    chk("rst_strobes",
        {ir_write_o, pc_inc_o, pc_branch_o, mem_read_o, mem_write_o,
         addr_sel_o, alu_src_b_o, alu_op_o, wb_sel_o, regwrite_o},
        32'd0);
    run_i = 1'b0;
    rst = 1'b0;
    exp_ret = 0;

    for (int v = 0; v < 8; v++) begin
      int n, rw, br, macc, irw, memcnt;
      logic [11:0] tr;
      logic [1:0] wb, alu;
      logic srcb, both, done;
      n = 0; rw = 0; br = 0; macc = 0; irw = 0; memcnt = 0;
      tr = '0; wb = '0; alu = '0; srcb = 1'b0;
      both = 1'b0; done = 1'b0;
      @(negedge clk);
      instr_i = vecs[v].instr;
      zero_i = vecs[v].zero;
      mem_ready_i = 1'b1;
      run_i = 1'b1;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        run_i = 1'b0;
        if (state_o == 3'd0) begin
          done = 1'b1;
          break;
        end
        if (state_o == 3'd4) begin
          memcnt++;
          mem_ready_i = (memcnt >= vecs[v].mem_cyc);
        end else begin
          mem_ready_i = 1'b1;
        end
        #1;
        n++;
        tr = {tr[8:0], state_o};
        rw += int'(regwrite_o);
        br += int'(pc_branch_o);
        irw += int'(ir_write_o & pc_inc_o);
        macc += int'((mem_read_o | mem_write_o) & addr_sel_o);
        both |= mem_read_o & mem_write_o;
        if (state_o == 3'd5) wb = wb_sel_o;
        if (state_o == 3'd3) begin
          alu = alu_op_o;
          srcb = alu_src_b_o;
        end
      end
      exp_ret++;
      chk($sformatf("v%0d_done", v), 32'(done), 32'd1);
      chk($sformatf("v%0d_cycles", v), n, vecs[v].n);
      chk($sformatf("v%0d_trace", v), 32'(tr), 32'(vecs[v].trace));
      chk($sformatf("v%0d_regwrite", v), rw, vecs[v].rw);
      chk($sformatf("v%0d_branch", v), br, vecs[v].br);
      chk($sformatf("v%0d_wbsel", v), 32'(wb), 32'(vecs[v].wb));
      chk($sformatf("v%0d_aluop", v), 32'(alu), 32'(vecs[v].alu));
      chk($sformatf("v%0d_srcb", v), 32'(srcb), 32'(vecs[v].srcb));
      chk($sformatf("v%0d_memacc", v), macc, vecs[v].macc);
      chk($sformatf("v%0d_irwrite", v), irw, 1);
      chk($sformatf("v%0d_rdwr_both", v), 32'(both), 32'd0);
      chk($sformatf("v%0d_retired", v), retired_o, 32'(exp_ret));
    end

    // Reset in the middle of a stalled store.
    @(negedge clk);
    instr_i = 32'h00112023;
    mem_ready_i = 1'b1;
    run_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      run_i = 1'b0;
      if (state_o == 3'd4) break;
    end
    mem_ready_i = 1'b0;
    #1;
    chk("st_in_mem", 32'(state_o), 32'd4);
    chk("st_mem_write", 32'(mem_write_o), 32'd1);
    chk("st_addr_sel", 32'(addr_sel_o), 32'd1);
    chk("st_pre_retired", retired_o, 32'(exp_ret));
    rst = 1'b1;
    #1;
    chk("st_rst_write", 32'(mem_write_o), 32'd0);
    chk("st_rst_state", 32'(state_o), 32'd0);
    chk("st_rst_retired", retired_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unknown opcode 0x7F.
    @(negedge clk);
    instr_i = 32'h0000007F;
    mem_ready_i = 1'b1;
    run_i = 1'b1;
    @(negedge clk);
    chk("ill_fetch", 32'(state_o), 32'd1);
    @(negedge clk);
    chk("ill_decode", 32'(state_o), 32'd2);
    @(negedge clk);
`ifdef CTRL_ILLEGAL_TRAP_EN
    run_i = 1'b0;
    chk("ill_trap_state", 32'(state_o), 32'd6);
    chk("ill_trap_flag", 32'(illegal_o), 32'd1);
    chk("ill_trap_retired", retired_o, 32'd0);
    repeat (3) @(negedge clk);
    chk("ill_trap_hold", 32'(state_o), 32'd6);
    chk("ill_trap_hold_flag", 32'(illegal_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("ill_rst_state", 32'(state_o), 32'd0);
    chk("ill_rst_flag", 32'(illegal_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`else
    chk("ill_nop_state", 32'(state_o), 32'd1);
    chk("ill_nop_retired", retired_o, 32'd1);
    chk("ill_nop_flag", 32'(illegal_o), 32'd0);
    mem_ready_i = 1'b0;
    run_i = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 The block SHALL have the parameter IW, default 32, meaning the instruction width in bits.
REQ-002 The block SHALL have the parameter CW, default 32, meaning the retired-instruction counter width in bits.
REQ-003 The block SHALL have the port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have the port run_i, input, width 1: enable for starting new instruction fetches.
REQ-006 The block SHALL have the port instr_i, input, width IW: instruction word from memory, valid when mem_ready_i is high in FETCH.
REQ-007 The block SHALL have the port mem_ready_i, input, width 1: memory transfer-complete strobe.
REQ-008 The block SHALL have the port zero_i, input, width 1: ALU zero flag, sampled in EXEC for branches.
REQ-009 The block SHALL have the port ir_write_o, output, width 1: latch instr_i into the instruction register.
REQ-010 The block SHALL have the port pc_inc_o, output, width 1: PC <= PC+4.
REQ-011 The block SHALL have the port pc_branch_o, output, width 1: PC <= PC_old+imm (taken branch or JAL).
REQ-012 The block SHALL have the port mem_read_o, output, width 1: memory read request.
REQ-013 The block SHALL have the port mem_write_o, output, width 1: memory write request.
REQ-014 The block SHALL have the port addr_sel_o, output, width 1: 0 selects the PC as memory address, 1 selects the ALU result.
REQ-015 The block SHALL have the port alu_src_b_o, output, width 1: 0 selects rdata2, 1 selects imme_o.
REQ-016 The block SHALL have the port alu_op_o, output, width 2: 00 add, 01 subtract/compare, 10 funct-decoded.
REQ-017 The block SHALL have the port wb_sel_o, output, width 2: 00 ALU result, 01 memory data, 10 PC+4.
REQ-018 The block SHALL have the port regwrite_o, output, width 1: register-file write strobe, driving the decoder's regwrite.
REQ-019 The block SHALL have the port state_o, output, width 3: current state encoding.
REQ-020 The block SHALL have the port illegal_o, output, width 1: an illegal opcode was trapped.
REQ-021 The block SHALL have the port retired_o, output, width CW: count of retired instructions.

Function
REQ-022 States and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
REQ-023 IDLE SHALL go to FETCH when run_i=1 and otherwise remain in IDLE.
REQ-024 FETCH SHALL assert mem_read_o with addr_sel_o=0 until mem_ready_i.
REQ-025 In the FETCH cycle where mem_ready_i=1, the block SHALL assert ir_write_o and pc_inc_o for that cycle only, latch opcode instr_i[6:0] and rd instr_i[11:7], and go to DECODE.
REQ-026 DECODE SHALL last 1 cycle.
REQ-027 DECODE SHALL classify the latched opcode as R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111 or JAL 1101111, and go to EXEC; any other opcode SHALL be handled per REQ-040/REQ-041.
REQ-028 In EXEC, the block SHALL drive alu_op_o=10 for R and I; alu_op_o=01 for BRANCH; and alu_op_o=00 otherwise.
REQ-029 In EXEC, the block SHALL drive alu_src_b_o=1 for I, LOAD, STORE and LUI, and 0 otherwise.
REQ-030 From EXEC, R, I and LUI SHALL go to WB; LOAD and STORE SHALL go to MEM.
REQ-031 From EXEC, BRANCH SHALL pulse pc_branch_o in EXEC iff zero_i=1, then go to FETCH (or IDLE if run_i=0).
REQ-032 From EXEC, JAL SHALL pulse pc_branch_o in EXEC and go to WB with wb_sel_o=10.
REQ-033 MEM SHALL drive addr_sel_o=1 and hold mem_read_o (LOAD) or mem_write_o (STORE) until mem_ready_i.
REQ-034 On mem_ready_i in MEM, LOAD SHALL go to WB with wb_sel_o=01, and STORE SHALL retire and go to FETCH/IDLE.
REQ-035 WB SHALL assert regwrite_o for exactly 1 cycle, suppressed when the latched rd=0, then retire and go to FETCH if run_i=1, else IDLE.
REQ-036 Retiring an instruction (leaving WB, STORE completion, BRANCH completion) SHALL increment retired_o by 1 and wrap modulo 2^CW.
REQ-037 mem_ready_i SHALL be ignored outside FETCH and MEM, and mem_read_o and mem_write_o SHALL never both be high.
REQ-038 Deasserting run_i mid-instruction SHALL let the instruction complete; the block SHALL stop in IDLE only at the retire point.
REQ-039 Latency with immediate mem_ready_i SHALL be: R/I/LUI/JAL 4 cycles; LOAD 5; STORE 4; BRANCH 3.

Reset
REQ-040 While rst=1, the state SHALL be IDLE, retired_o=0, illegal_o=0, and all strobes and selects 0.
REQ-041 Asserting rst mid-operation SHALL abort any transfer immediately without a write strobe.

Configuration
REQ-042 With CTRL_ILLEGAL_TRAP_EN defined, an unclassified opcode in DECODE SHALL go to TRAP, set illegal_o=1, and hold there until rst, with no retire.
REQ-043 Without CTRL_ILLEGAL_TRAP_EN, an unclassified opcode SHALL be retired as a NOP (DECODE to FETCH/IDLE), illegal_o SHALL be tied 0, and the TRAP state SHALL be absent.

Structure
REQ-044 A shared package SHALL hold the state enum, the opcode constants, and the alu_op_o and wb_sel_o encodings.
REQ-045 Opcode classification SHALL be one sub-module, cpu_opclass_dec, that is combinational: opcode in, one-hot class out.

Verification
REQ-046 The bench SHALL cover: run_i=1, instr 0x002081B3 (add x3), mem_ready_i immediate -> states 1,2,3,5; regwrite_o high in cycle 4; retired_o=1.
REQ-047 The bench SHALL cover: LOAD 0x0000A103 with mem_ready_i delayed 3 cycles in MEM -> mem_read_o held 3 cycles with addr_sel_o=1, then WB with wb_sel_o=01.
REQ-048 The bench SHALL cover: BRANCH 0x00208463 with zero_i=1 vs 0 -> pc_branch_o pulses only when zero_i=1; regwrite_o never asserted; retired_o increments.
REQ-049 The bench SHALL cover: instr 0x00000013 with rd=0 -> regwrite_o stays 0 in WB.
REQ-050 The bench SHALL cover: opcode 0x7F -> with CTRL_ILLEGAL_TRAP_EN, state_o=6 and illegal_o=1 until rst; without it, retired_o+1 and return to FETCH.
REQ-051 The bench SHALL cover: rst pulse during MEM of a STORE -> mem_write_o drops at once; state_o=0 and retired_o=0.
